// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_port_arbiter_if                                          |
// | Brief    : Requester and SRAM-pin bundle for the packet-buffer arbiter   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            wr_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            wr_gnt;
  logic [NUM_REQ-1:0]            rd_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]            rd_gnt;
  logic [NUM_REQ-1:0]            rd_vld;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          sram_wr_en;
  logic [ADDR_WIDTH-1:0]         sram_wr_addr;
  logic [DATA_WIDTH-1:0]         sram_din;
  logic                          sram_rd_en;
  logic [ADDR_WIDTH-1:0]         sram_rd_addr;
  logic [DATA_WIDTH-1:0]         sram_dout;

  // Arbiter side
  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
    output wr_gnt, rd_gnt, rd_vld, rd_data,
    output sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr
  );

  // Requesters plus SRAM macro side
  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
    input  wr_gnt, rd_gnt, rd_vld, rd_data,
    input  sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr
  );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_port_arbiter                                             |
// | Brief    : Round-robin sharing of the packet-buffer SRAM write and read  |
// |            ports, with same-address read-during-write protection.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  io_bus
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; MSB of the result flags a winner.
  function automatic logic [c_PTR_W:0] f_rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [c_PTR_W-1:0] ptr
  );
    logic               found;
    logic [c_PTR_W-1:0] idx;
    logic [c_PTR_W-1:0] cand;
    int                 pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = c_PTR_W'(pos);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] idx);
    return (idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : idx + c_PTR_W'(1);
  endfunction

  logic [ADDR_WIDTH-1:0] w_wr_addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wr_data_a [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_rd_addr_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_wr_addr_a[gi] = io_bus.wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wr_data_a[gi] = io_bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_rd_addr_a[gi] = io_bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;

  logic [c_PTR_W:0]      w_wr_pick;
  logic [c_PTR_W:0]      w_rd_pick;
  logic                  w_wr_any;
  logic                  w_rd_any;
  logic [c_PTR_W-1:0]    w_wr_idx;
  logic [c_PTR_W-1:0]    w_rd_idx;
  logic                  w_hazard;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [NUM_REQ-1:0]    w_wr_gnt;
  logic [NUM_REQ-1:0]    w_rd_gnt;

  // Issue stage registers drive the SRAM pins directly
  logic                  r_sram_wr_en;
  logic [ADDR_WIDTH-1:0] r_sram_wr_addr;
  logic [DATA_WIDTH-1:0] r_sram_din;
  logic                  r_sram_rd_en;
  logic [ADDR_WIDTH-1:0] r_sram_rd_addr;
  logic [c_PTR_W-1:0]    r_rd_tag1;

  // Return stage: aligned with the SRAM's registered dout
  logic                  r_rd_vld2;
  logic [c_PTR_W-1:0]    r_rd_tag2;
  logic [DATA_WIDTH-1:0] r_rd_data_hold;
  logic                  w_ret_vld;
  logic [NUM_REQ-1:0]    w_rd_vld;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_wr_pick = f_rr_pick(io_bus.wr_req, r_wr_ptr);
  assign w_rd_pick = f_rr_pick(io_bus.rd_req, r_rd_ptr);
  assign w_wr_any  = w_wr_pick[c_PTR_W];
  assign w_rd_any  = w_rd_pick[c_PTR_W];
  assign w_wr_idx  = w_wr_pick[c_PTR_W-1:0];
  assign w_rd_idx  = w_rd_pick[c_PTR_W-1:0];

  // A same-cycle write and read to one address would read stale data; the read waits.
  assign w_hazard  = w_wr_any && w_rd_any &&
                     (w_wr_addr_a[w_wr_idx] == w_rd_addr_a[w_rd_idx]);
  assign w_wr_fire = w_wr_any && !rst;
  assign w_rd_fire = w_rd_any && !rst && !w_hazard;

  assign w_wr_gnt  = w_wr_fire ? (NUM_REQ'(1) << w_wr_idx) : '0;
  assign w_rd_gnt  = w_rd_fire ? (NUM_REQ'(1) << w_rd_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= f_next(w_wr_idx);
      if (w_rd_fire) r_rd_ptr <= f_next(w_rd_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_wr_en   <= 1'b0;
      r_sram_wr_addr <= '0;
      r_sram_din     <= '0;
      r_sram_rd_en   <= 1'b0;
      r_sram_rd_addr <= '0;
      r_rd_tag1      <= '0;
    end else begin
      r_sram_wr_en <= w_wr_fire;
      r_sram_rd_en <= w_rd_fire;
      if (w_wr_fire) begin
        r_sram_wr_addr <= w_wr_addr_a[w_wr_idx];
        r_sram_din     <= w_wr_data_a[w_wr_idx];
      end
      if (w_rd_fire) begin
        r_sram_rd_addr <= w_rd_addr_a[w_rd_idx];
        r_rd_tag1      <= w_rd_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld2      <= 1'b0;
      r_rd_tag2      <= '0;
      r_rd_data_hold <= '0;
    end else begin
      r_rd_vld2 <= r_sram_rd_en;
      r_rd_tag2 <= r_rd_tag1;
      if (r_rd_vld2) r_rd_data_hold <= io_bus.sram_dout;
    end
  end

  // Commands already in the issue/return stages are dropped while rst is high.
  assign w_ret_vld = r_rd_vld2 && !rst;
  assign w_rd_vld  = w_ret_vld ? (NUM_REQ'(1) << r_rd_tag2) : '0;
  assign w_rd_data = w_ret_vld ? io_bus.sram_dout : r_rd_data_hold;

  assign io_bus.wr_gnt       = w_wr_gnt;
  assign io_bus.rd_gnt       = w_rd_gnt;
  assign io_bus.rd_vld       = w_rd_vld;
  assign io_bus.rd_data      = w_rd_data;
  assign io_bus.sram_wr_en   = r_sram_wr_en && !rst;
  assign io_bus.sram_wr_addr = r_sram_wr_addr;
  assign io_bus.sram_din     = r_sram_din;
  assign io_bus.sram_rd_en   = r_sram_rd_en && !rst;
  assign io_bus.sram_rd_addr = r_sram_rd_addr;

endmodule
`default_nettype wire
